// File: rtl/alu_loader_pkg.sv
// alu_loader_pkg: shared state encoding, opcode constants and err bit indices for the ALU operand loader
// Optional feature macro: LOADER_CHK_EN adds the GET_CHK state.
package alu_loader_pkg;
    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        GET_OP,
`ifdef LOADER_CHK_EN
        GET_CHK,
`endif
        ISSUE
    } state_t;
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_NOR  = 3'd6;
    localparam logic [2:0] OP_NOT  = 3'd7;
    localparam int ERR_TMO = 0;
    localparam int ERR_CHK = 1;
endpackage

// File: rtl/loader_idle_timer.sv
// loader_idle_timer: idle-cycle counter between frame bytes
// Ports: clk, rst (sync, active-high), clr (zero the count), cnt_en (count one idle cycle),
//        expired (count has reached TIMEOUT_CYCLES; never set when TIMEOUT_CYCLES is 0).
module loader_idle_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cnt_en,
    output logic expired
);
    localparam int W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [W-1:0] cnt;
    assign expired = (TIMEOUT_CYCLES != 0) && (cnt == W'(TIMEOUT_CYCLES));
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (cnt_en && !expired)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: assembles A, B, OP (and optional CHK) bytes into one registered ALU issue
// Ports: clk, rst (sync, active-high), ena (global hold),
//        in_byte/in_valid/in_ready (byte stream in),
//        a_out/b_out/op_out/issue_valid/issue_ready (issue to ALU),
//        busy (frame in progress or issue pending), err (sticky: bit0 timeout, bit1 checksum).
// Optional feature macro: LOADER_CHK_EN appends a CHK byte (A ^ B ^ OP byte) to each frame.
module alu_operand_loader
    import alu_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] a_out,
    output logic [7:0] b_out,
    output logic [2:0] op_out,
    output logic       issue_valid,
    input  logic       issue_ready,
    output logic       busy,
    output logic [1:0] err
);
    state_t state, nxt;
    logic acc, timed, tmo, expired;
    assign in_ready    = ena && (state != ISSUE);
    assign acc         = in_valid && in_ready;
    assign issue_valid = (state == ISSUE);
    assign busy        = (state != GET_A);
    assign timed       = busy && !issue_valid;
    // a byte landing on the expiry edge wins over the timeout
    assign tmo         = ena && timed && !acc && expired;

`ifdef LOADER_CHK_EN
    logic [7:0] op_byte;
    logic       chk_ok;
    assign chk_ok = (in_byte == (a_out ^ b_out ^ op_byte));
`endif

    loader_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (ena && (acc || !timed || tmo)),
        .cnt_en (ena && timed && !acc),
        .expired(expired)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            GET_A:   nxt = acc ? GET_B : GET_A;
            GET_B:   nxt = acc ? GET_OP : (tmo ? GET_A : GET_B);
`ifdef LOADER_CHK_EN
            GET_OP:  nxt = acc ? GET_CHK : (tmo ? GET_A : GET_OP);
            GET_CHK: nxt = acc ? (chk_ok ? ISSUE : GET_A) : (tmo ? GET_A : GET_CHK);
`else
            GET_OP:  nxt = acc ? ISSUE : (tmo ? GET_A : GET_OP);
`endif
            ISSUE:   nxt = (ena && issue_ready) ? GET_A : ISSUE;
            default: nxt = GET_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= GET_A;
            a_out  <= '0;
            b_out  <= '0;
            op_out <= '0;
            err    <= '0;
        end else begin
            state <= nxt;
            if (acc && state == GET_A)
                a_out <= in_byte;
            if (acc && state == GET_B)
                b_out <= in_byte;
            if (acc && state == GET_OP)
                op_out <= in_byte[2:0];
            err[ERR_TMO] <= err[ERR_TMO] | tmo;
`ifdef LOADER_CHK_EN
            err[ERR_CHK] <= err[ERR_CHK] | (acc && state == GET_CHK && !chk_ok);
`else
            err[ERR_CHK] <= 1'b0;
`endif
        end
    end

`ifdef LOADER_CHK_EN
    always_ff @(posedge clk) begin
        if (rst)
            op_byte <= '0;
        else if (acc && state == GET_OP)
            op_byte <= in_byte;
    end
`endif
endmodule
